// File: rtl/vga_line_fetch_arbiter_if.sv
// Shared RAM port and SPI loader write stream seen by the line fetch arbiter.
// The master side is the arbiter; the slave side is the RAM plus loader.
interface vga_line_fetch_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic              mem_wr_en;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] mem_rdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_gnt;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, wr_gnt,
        input  mem_rdata, wr_req, wr_addr, wr_data
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata, wr_gnt,
        output mem_rdata, wr_req, wr_addr, wr_data
    );
endinterface

// File: rtl/vga_line_fetch_arbiter.sv
// Burst-fetches 1 bpp source rows into ping-pong line buffers for an upscaled
// VGA output, sharing the single RAM port with the SPI loader's write stream.
module vga_line_fetch_arbiter #(
    parameter int SRC_W   = 200,
    parameter int SRC_H   = 150,
    parameter int SCALE   = 4,
    parameter int WORD_W  = 8,
    parameter int ADDR_W  = 12,
    parameter int H_AREA  = 800,
    parameter int V_AREA  = 600,
    parameter int Y_TOTAL = 628,
    parameter int X_W     = 11,
    parameter int Y_W     = 10
) (
    input  logic           CLK_40,
    input  logic           reset_n,
    input  logic [X_W-1:0] x_pos,
    input  logic [Y_W-1:0] y_pos,
    output logic           pixel_color,
    output logic           fetch_late,
    vga_line_fetch_arbiter_if.master bus
);
    localparam int WPR   = SRC_W / WORD_W;
    localparam int SHIFT = $clog2(SCALE);
    localparam int K_W   = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int IDX_W = (SRC_W > 1) ? $clog2(SRC_W) : 1;

    generate
        if ((SCALE & (SCALE - 1)) != 0) begin : g_bad_scale
            $error("SCALE must be a power of two");
        end
        if ((SRC_W % WORD_W) != 0) begin : g_bad_width
            $error("SRC_W must be a multiple of WORD_W");
        end
        if ((2 ** ADDR_W) < (SRC_W * SRC_H / WORD_W)) begin : g_bad_addr
            $error("ADDR_W too narrow for the frame");
        end
        if (H_AREA != SRC_W * SCALE || V_AREA != SRC_H * SCALE) begin : g_bad_area
            $error("H_AREA/V_AREA must equal the scaled source size");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] base_addr;
    logic              target_bank;
    logic [K_W-1:0]    word_cnt;
    logic              disp_bank;
    logic              cap_valid;
    logic [K_W-1:0]    cap_idx;

    logic [SRC_W-1:0]  line_buf [2];

    // Schedule decode, only meaningful on the first horizontal-blank pixel.
    logic              hblank_evt;
    logic              in_body;
    logic [Y_W-1:0]    phase;
    logic              preload;
    logic              fetch_next;
    logic              swap;
    logic              trigger;
    logic [ADDR_W-1:0] fetch_base;

    assign hblank_evt = (x_pos == X_W'(H_AREA));
    assign in_body    = (y_pos < Y_W'(V_AREA - SCALE));
    assign phase      = y_pos & Y_W'(SCALE - 1);
    assign preload    = hblank_evt && (y_pos == Y_W'(Y_TOTAL - 2));
    assign fetch_next = hblank_evt && in_body && (phase == '0);
    assign swap       = hblank_evt && ((in_body && (phase == Y_W'(SCALE - 1)))
                                       || (y_pos == Y_W'(Y_TOTAL - 1)));
    assign trigger    = preload || fetch_next;
    assign fetch_base = preload ? '0 : ADDR_W'((int'(y_pos >> SHIFT) + 1) * WPR);

    logic              rd_en;
    logic              wr_en;
    logic              gnt;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        gnt     = 1'b0;
        addr    = '0;
        wdata   = '0;
        unique case (state)
            IDLE: begin
                if (trigger) begin
                    state_n = FETCH;
                end else if (bus.wr_req && reset_n) begin
                    // NOTE: the grant is combinational, so reset must gate it explicitly.
                    gnt   = 1'b1;
                    wr_en = 1'b1;
                    addr  = bus.wr_addr;
                    wdata = bus.wr_data;
                end
            end
            FETCH: begin
                rd_en = 1'b1;
                addr  = base_addr + ADDR_W'(word_cnt);
                if (word_cnt == K_W'(WPR - 1)) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_wr_en = wr_en;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = wdata;
    assign bus.wr_gnt    = gnt;

    logic             visible;
    logic [IDX_W-1:0] x_idx;

    assign visible = (x_pos < X_W'(H_AREA)) && (y_pos < Y_W'(V_AREA));
    assign x_idx   = IDX_W'(x_pos >> SHIFT);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            base_addr   <= '0;
            target_bank <= 1'b0;
            word_cnt    <= '0;
            disp_bank   <= 1'b0;
            fetch_late  <= 1'b0;
            cap_valid   <= 1'b0;
            cap_idx     <= '0;
            pixel_color <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && trigger) begin
                base_addr   <= fetch_base;
                target_bank <= ~disp_bank;
                word_cnt    <= '0;
            end else if (state == FETCH) begin
                word_cnt <= word_cnt + K_W'(1);
            end
            // Read data arrives one cycle after the strobe; remember where it goes.
            cap_valid <= (state == FETCH);
            cap_idx   <= word_cnt;
            // A late swap still happens; the running fetch keeps its original bank.
            if (swap) begin
                disp_bank <= ~disp_bank;
            end
            if ((swap || trigger) && state != IDLE) begin
                fetch_late <= 1'b1;
            end
            pixel_color <= visible ? line_buf[disp_bank][x_idx] : 1'b0;
        end
    end

    // NOTE: line buffers are plain storage with no reset; every row is rewritten before display.
    always_ff @(posedge CLK_40) begin
        if (cap_valid) begin
            line_buf[target_bank][int'(cap_idx) * WORD_W +: WORD_W] <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_vga_line_fetch_arbiter.sv
// Scoreboard bench: the driver predicts reads, grants, pixels and the late flag
// from the screen schedule and a RAM image; a negedge monitor compares.
module tb_vga_line_fetch_arbiter;
    localparam int WPR = 25;

    logic        CLK_40 = 1'b0;
    logic        reset_n;
    logic [10:0] x_pos;
    logic [9:0]  y_pos;
    logic        pixel_color;
    logic        fetch_late;

    always #5 CLK_40 = ~CLK_40;

    vga_line_fetch_arbiter_if #(.ADDR_W(12), .WORD_W(8)) bus ();

    vga_line_fetch_arbiter dut (
        .CLK_40      (CLK_40),
        .reset_n     (reset_n),
        .x_pos       (x_pos),
        .y_pos       (y_pos),
        .pixel_color (pixel_color),
        .fetch_late  (fetch_late),
        .bus         (bus)
    );

    typedef struct {
        int          cyc;
        logic [31:0] val;
    } exp_t;

    exp_t rd_q[$];
    exp_t pix_q[$];
    exp_t gnt_q[$];
    exp_t late_q[$];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 0;
    bit   stream_en = 0;
    bit   chk_pix = 0;
    int   busy_from = -100;
    int   busy_to = -100;
    logic exp_late = 1'b0;
    logic prev_gnt = 1'b0;

    logic [7:0] ram [0:4095];

    always @(posedge CLK_40) cyc <= cyc + 1;

    // RAM model: read data one cycle after the strobe, writes land at the edge.
    always @(posedge CLK_40) begin
        if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_addr];
        if (bus.mem_wr_en) ram[bus.mem_addr] = bus.mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    // Screen pixel (x, y) shows source pixel (x/4, y/4) of the stored image.
    function automatic logic exp_pixel(input int x, input int y);
        int         col;
        logic [7:0] w;
        if (x >= 800 || y >= 600) return 1'b0;
        col = x / 4;
        w   = ram[(y / 4) * WPR + col / 8];
        return w[col % 8];
    endfunction

    always @(negedge CLK_40) begin
        if (mon_en && reset_n) begin
            exp_t e;
            check("rd_wr_exclusive", 32'(bus.mem_rd_en & bus.mem_wr_en), 0);
            if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
                e = rd_q.pop_front();
                check("mem_rd_en", 32'(bus.mem_rd_en), 1);
                check("mem_rd_addr", 32'(bus.mem_addr), e.val);
            end else begin
                check("mem_rd_idle", 32'(bus.mem_rd_en), 0);
            end
            if (gnt_q.size() > 0 && gnt_q[0].cyc == cyc) begin
                e = gnt_q.pop_front();
                check("wr_gnt", 32'(bus.wr_gnt), 32'(e.val[20]));
                check("mem_wr_en", 32'(bus.mem_wr_en), 32'(e.val[20]));
                if (e.val[20]) begin
                    check("mem_wr_addr", 32'(bus.mem_addr), 32'(e.val[19:8]));
                    check("mem_wdata", 32'(bus.mem_wdata), 32'(e.val[7:0]));
                end
            end
            if (pix_q.size() > 0 && pix_q[0].cyc == cyc) begin
                e = pix_q.pop_front();
                check("pixel_color", 32'(pixel_color), e.val);
            end
            if (late_q.size() > 0 && late_q[0].cyc == cyc) begin
                e = late_q.pop_front();
                check("fetch_late", 32'(fetch_late), e.val);
            end
        end
    end

    // One pixel-clock cycle of stimulus plus the predictions it implies.
    task automatic drive(input int x, input int y);
        int   c;
        bit   trig;
        bit   sw;
        bit   busy;
        int   row;
        logic g;
        c = cyc;
        if (stream_en && (!bus.wr_req || prev_gnt)) begin
            bus.wr_req  = ($urandom_range(3) == 0);
            bus.wr_addr = 12'($urandom_range(4095, 3750));
            bus.wr_data = 8'($urandom);
        end
        x_pos = 11'(x);
        y_pos = 10'(y);
        trig = 0;
        sw   = 0;
        row  = 0;
        if (x == 800) begin
            if (y == 626) begin
                trig = 1;
                row  = 0;
            end else if (y < 596 && y % 4 == 0) begin
                trig = 1;
                row  = y / 4 + 1;
            end
            sw = (y < 596 && y % 4 == 3) || (y == 627);
        end
        busy = (c >= busy_from && c <= busy_to);
        if ((trig || sw) && busy) exp_late = 1'b1;
        if (trig && !busy) begin
            busy_from = c + 1;
            busy_to   = c + WPR + 1;
            for (int i = 0; i < WPR; i++) rd_q.push_back('{cyc: c + 1 + i, val: 32'(row * WPR + i)});
        end
        g = bus.wr_req && !busy && !trig;
        gnt_q.push_back('{cyc: c, val: {11'd0, g, bus.wr_addr, bus.wr_data}});
        prev_gnt = g;
        late_q.push_back('{cyc: c + 1, val: 32'(exp_late)});
        if (chk_pix) pix_q.push_back('{cyc: c + 1, val: 32'(exp_pixel(x, y))});
        @(posedge CLK_40);
        #1;
    endtask

    task automatic run_line(input int y, input bit with_pixels);
        chk_pix = with_pixels;
        if (with_pixels) for (int x = 0; x < 800; x++) drive(x, y);
        for (int x = 800; x < 836; x++) drive(x, y);
        chk_pix = 0;
    endtask

    task automatic flush_queues();
        rd_q.delete();
        pix_q.delete();
        gnt_q.delete();
        late_q.delete();
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) ram[a] = 8'($urandom);
        ram[0] = 8'h05;
        reset_n     = 1'b0;
        x_pos       = '0;
        y_pos       = '0;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 12'h3F0;
        bus.wr_data = 8'h5A;
        repeat (3) @(posedge CLK_40);
        @(negedge CLK_40);
        check("rst_pixel_color", 32'(pixel_color), 0);
        check("rst_mem_rd_en", 32'(bus.mem_rd_en), 0);
        check("rst_mem_wr_en", 32'(bus.mem_wr_en), 0);
        check("rst_wr_gnt", 32'(bus.wr_gnt), 0);
        check("rst_fetch_late", 32'(fetch_late), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_wdata", 32'(bus.mem_wdata), 0);
        @(posedge CLK_40);
        #1;
        reset_n    = 1'b1;
        bus.wr_req = 1'b0;
        mon_en     = 1;
        stream_en  = 1;

        // Warm-up: preload row 0 at line 626, swap at 627.
        for (int y = 620; y < 628; y++) run_line(y, 0);

        // One full frame with pixel checks on selected lines.
        for (int y = 0; y < 628; y++) begin
            bit pix;
            pix = (y == 0 || y == 1 || y == 4 || y == 5 || y == 44 || y == 100 ||
                   y == 592 || y == 595 || y == 596 || y == 599 || y == 600);
            if (y == 4) begin
                stream_en  = 0;
                bus.wr_req = 1'b0;
                chk_pix    = 1;
                for (int x = 0; x < 800; x++) drive(x, y);
                bus.wr_req  = 1'b1;
                bus.wr_addr = 12'h123;
                bus.wr_data = 8'hAA;
                for (int x = 800; x < 836; x++) begin
                    drive(x, y);
                    if (prev_gnt) bus.wr_req = 1'b0;
                end
                chk_pix   = 0;
                stream_en = 1;
            end else begin
                run_line(y, pix);
            end
        end

        // Swap while a fetch is running.
        drive(800, 8);
        for (int x = 801; x < 806; x++) drive(x, 8);
        drive(800, 11);
        for (int x = 801; x < 840; x++) drive(x, 11);

        // Reset mid-fetch at word 10.
        stream_en = 0;
        bus.wr_req = 1'b0;
        drive(800, 16);
        for (int x = 801; x < 811; x++) drive(x, 16);
        @(negedge CLK_40);
        check("rd_en_before_reset", 32'(bus.mem_rd_en), 1);
        #2;
        reset_n = 1'b0;
        mon_en  = 0;
        flush_queues();
        #1;
        check("rd_en_async_drop", 32'(bus.mem_rd_en), 0);
        check("late_cleared_by_reset", 32'(fetch_late), 0);
        repeat (3) @(posedge CLK_40);
        #1;
        reset_n   = 1'b1;
        busy_from = -100;
        busy_to   = -100;
        exp_late  = 1'b0;
        prev_gnt  = 1'b0;
        mon_en    = 1;
        bus.wr_req  = 1'b1;
        bus.wr_addr = 12'hF00;
        bus.wr_data = 8'h3C;
        drive(820, 16);
        bus.wr_req = 1'b0;
        for (int x = 821; x < 826; x++) drive(x, 16);

        // Trigger while a fetch is running.
        stream_en = 1;
        drive(800, 20);
        for (int x = 801; x < 806; x++) drive(x, 20);
        drive(800, 24);
        for (int x = 801; x < 840; x++) drive(x, 24);
        for (int x = 840; x < 850; x++) drive(x, 610);

        check("rd_q_drained", 32'(rd_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
